traffic_light_monitor: RTL and testbench

- Passive checker on the far end of the four-way light bus driven by traffic_lights.
- Samples S/W/N/E light codes every cycle and checks them for:
  - illegal encodings
  - conflicting right-of-way
  - illegal colour transitions
  - yellow and green dwell-time violations
- Reports errors as a one-cycle pulse plus sticky flags, and counts completed green phases.
- Instantiated beside the controller in system benches and in the FPGA top for on-board self-check.

---
 rtl/traffic_light_monitor.sv | 146 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker for the four-way traffic light bus
// Samples S/W/N/E codes, flags encoding, conflict, transition and dwell errors, counts green phases.
module traffic_light_monitor #(
  parameter int YELLOW_MIN = 3,
  parameter int YELLOW_MAX = 6,
  parameter int GREEN_MAX  = 20,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  S_light,
  input  logic [1:0]  W_light,
  input  logic [1:0]  N_light,
  input  logic [1:0]  E_light,
  input  logic        clr_err,
  output logic        err_pulse,
  output logic [4:0]  err_flags,
  output logic [1:0]  err_dir,
  output logic [15:0] phase_cnt
);

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;
  localparam logic [1:0] INV = 2'b11;

  logic [3:0][1:0]       light_in;
  logic [3:0][1:0]       cur_q, prev_q;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  cur_valid_q, prev_valid_q;

  logic                  err_pulse_q;
  logic [4:0]            err_flags_q, err_flags_d;
  logic [1:0]            err_dir_q, err_dir_d;
  logic [15:0]           phase_cnt_q, phase_cnt_d;

  logic [3:0]            f_inv, f_trans, f_ydw, f_gdw, non_red, fail_dir;
  logic                  conflict, any_fail;
  logic [4:0]            fail_vec;
  logic [2:0]            phase_inc;
  logic [16:0]           phase_sum;

  assign light_in = {E_light, N_light, W_light, S_light};

  // prev_valid_q only rises once prev_q holds a real sample, not the reset red
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q        <= {4{RED}};
      prev_q       <= {4{RED}};
      cnt_q        <= '0;
      cur_valid_q  <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      cur_q        <= light_in;
      prev_q       <= cur_q;
      cnt_q        <= cnt_d;
      cur_valid_q  <= 1'b1;
      prev_valid_q <= cur_valid_q;
    end
  end

  // cnt_d is the dwell of the run ending in cur_q; cnt_q is the dwell of prev_q's run
  always_comb begin
    cnt_d = cnt_q;
    for (int d = 0; d < 4; d++) begin
      if (cur_q[d] != prev_q[d])
        cnt_d[d] = CNT_W'(1);
      else if (&cnt_q[d])
        cnt_d[d] = cnt_q[d];
      else
        cnt_d[d] = cnt_q[d] + CNT_W'(1);
    end
  end

  always_comb begin
    f_inv     = '0;
    f_trans   = '0;
    f_ydw     = '0;
    f_gdw     = '0;
    non_red   = '0;
    phase_inc = '0;
    for (int d = 0; d < 4; d++) begin
      non_red[d] = (cur_q[d] != RED);
      f_inv[d]   = (cur_q[d] == INV);
      if (prev_valid_q) begin
        f_trans[d] = (prev_q[d] == GRN && cur_q[d] == RED) ||
                     (prev_q[d] == RED && cur_q[d] == YEL) ||
                     (prev_q[d] == YEL && cur_q[d] == GRN);
        f_ydw[d]   = (prev_q[d] == YEL) && (cur_q[d] == RED) &&
                     ((cnt_q[d] < CNT_W'(YELLOW_MIN)) || (cnt_q[d] > CNT_W'(YELLOW_MAX)));
        f_gdw[d]   = (prev_q[d] == GRN) && (cur_q[d] == GRN) &&
                     (cnt_d[d] == CNT_W'(GREEN_MAX + 1));
        if (prev_q[d] == RED && cur_q[d] == GRN)
          phase_inc = phase_inc + 3'd1;
      end
    end
  end

  assign conflict = ($countones(non_red) > 1);
  assign fail_dir = f_inv | f_trans | f_ydw | f_gdw;
  assign fail_vec = {|f_gdw, |f_ydw, |f_trans, conflict, |f_inv};
  assign any_fail = |fail_vec;

  // a conflict with no per-direction failure names the highest non-red direction
  always_comb begin
    err_dir_d = err_dir_q;
    if (|fail_dir) begin
      for (int d = 3; d >= 0; d--)
        if (fail_dir[d]) err_dir_d = 2'(d);
    end else if (conflict) begin
      for (int d = 0; d < 4; d++)
        if (non_red[d]) err_dir_d = 2'(d);
    end
  end

  always_comb begin
    err_flags_d = (clr_err ? 5'b0 : err_flags_q) | fail_vec;
    phase_sum   = {1'b0, phase_cnt_q} + 17'(phase_inc);
    if (clr_err)
      phase_cnt_d = '0;
    else if (phase_sum[16])
      phase_cnt_d = 16'hFFFF;
    else
      phase_cnt_d = phase_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_flags_q <= '0;
      err_dir_q   <= '0;
      phase_cnt_q <= '0;
    end else begin
      err_pulse_q <= any_fail;
      err_flags_q <= err_flags_d;
      err_dir_q   <= err_dir_d;
      phase_cnt_q <= phase_cnt_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_flags = err_flags_q;
  assign err_dir   = err_dir_q;
  assign phase_cnt = phase_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - self-checking bench for traffic_light_monitor
// Reference model keeps the full sample history and derives dwell by scanning runs.
module tb_traffic_light_monitor;

  localparam int YMIN = 3;
  localparam int YMAX = 6;
  localparam int GMAX = 20;
  localparam int HMAX = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  s_l = 2'b00, w_l = 2'b00, n_l = 2'b00, e_l = 2'b00;
  logic        clr = 1'b0;
  logic        err_pulse;
  logic [4:0]  err_flags;
  logic [1:0]  err_dir;
  logic [15:0] phase_cnt;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .YELLOW_MIN(YMIN), .YELLOW_MAX(YMAX), .GREEN_MAX(GMAX), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .S_light(s_l), .W_light(w_l), .N_light(n_l), .E_light(e_l),
    .clr_err(clr),
    .err_pulse(err_pulse), .err_flags(err_flags), .err_dir(err_dir), .phase_cnt(phase_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  hist [0:HMAX-1];
  int          n_samp;
  logic [4:0]  pend_fail;
  logic [1:0]  pend_dir;
  logic        pend_dir_upd;
  int          pend_inc;
  logic        exp_pulse;
  logic [4:0]  exp_flags;
  logic [1:0]  exp_dir;
  int          exp_phase;
  int          pulse_seen;
  int          step_no;
  int          pulse_at;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] code_at(int j, int d);
    logic [7:0] v;
    v = hist[j];
    return v[2*d +: 2];
  endfunction

  function automatic int run_len(int d, int idx);
    int r = 0;
    for (int j = idx; j >= 0; j--) begin
      if (code_at(j, d) != code_at(idx, d)) break;
      r++;
    end
    return (r > 255) ? 255 : r;
  endfunction

  task automatic model_reset();
    n_samp = 0; pend_fail = '0; pend_dir = '0; pend_dir_upd = 1'b0; pend_inc = 0;
    exp_pulse = 1'b0; exp_flags = '0; exp_dir = '0; exp_phase = 0;
  endtask

  task automatic eval_pending();
    int idx, nr, hi_nr, yl;
    logic [3:0] fd;
    logic [1:0] c, p;
    idx = n_samp - 1; nr = 0; hi_nr = 0; fd = '0;
    pend_fail = '0; pend_inc = 0; pend_dir_upd = 1'b0;
    for (int d = 0; d < 4; d++) begin
      c = code_at(idx, d);
      if (c != 2'b00) begin nr++; hi_nr = d; end
      if (c == 2'b11) begin fd[d] = 1'b1; pend_fail[0] = 1'b1; end
      if (idx >= 1) begin
        p = code_at(idx - 1, d);
        if ((p == 2'b10 && c == 2'b00) || (p == 2'b00 && c == 2'b01) || (p == 2'b01 && c == 2'b10)) begin
          fd[d] = 1'b1; pend_fail[2] = 1'b1;
        end
        if (p == 2'b01 && c == 2'b00) begin
          yl = run_len(d, idx - 1);
          if (yl < YMIN || yl > YMAX) begin fd[d] = 1'b1; pend_fail[3] = 1'b1; end
        end
        if (c == 2'b10 && run_len(d, idx) == GMAX + 1) begin fd[d] = 1'b1; pend_fail[4] = 1'b1; end
        if (p == 2'b00 && c == 2'b10) pend_inc++;
      end
    end
    if (nr > 1) pend_fail[1] = 1'b1;
    if (fd != 4'b0) begin
      pend_dir_upd = 1'b1;
      for (int d = 3; d >= 0; d--) if (fd[d]) pend_dir = 2'(d);
    end else if (nr > 1) begin
      pend_dir_upd = 1'b1;
      pend_dir = 2'(hi_nr);
    end
  endtask

  // Called just after a rising edge (+1): drives the next sample, then checks outputs.
  task automatic step(input logic [1:0] s, input logic [1:0] w, input logic [1:0] n,
                      input logic [1:0] e, input logic c);
    s_l = s; w_l = w; n_l = n; e_l = e; clr = c;
    @(posedge clk);
    exp_pulse = |pend_fail;
    exp_flags = (c ? 5'b0 : exp_flags) | pend_fail;
    if (pend_dir_upd) exp_dir = pend_dir;
    exp_phase = c ? 0 : ((exp_phase + pend_inc > 65535) ? 65535 : exp_phase + pend_inc);
    if (n_samp >= HMAX) begin
      $display("FAIL history overflow");
      $fatal(1, "history overflow");
    end
    hist[n_samp] = {e, n, w, s};
    n_samp++;
    eval_pending();
    #1;
    step_no++;
    if (err_pulse === 1'b1) begin pulse_seen++; if (pulse_at == 0) pulse_at = step_no; end
    check("err_pulse", 16'(err_pulse), 16'(exp_pulse));
    check("err_flags", 16'(err_flags), 16'(exp_flags));
    check("err_dir", 16'(err_dir), 16'(exp_dir));
    check("phase_cnt", phase_cnt, 16'(exp_phase));
  endtask

  task automatic step_dir(input int d, input logic [1:0] code, input int n);
    logic [1:0] v [4];
    for (int i = 0; i < 4; i++) v[i] = 2'b00;
    v[d] = code;
    repeat (n) step(v[0], v[1], v[2], v[3], 1'b0);
  endtask

  task automatic settle();
    step(0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 1'b1);
    step(0, 0, 0, 0, 1'b0);
    pulse_seen = 0; step_no = 0; pulse_at = 0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pulse", 16'(err_pulse), 16'h0);
    check("rst_flags", 16'(err_flags), 16'h0);
    check("rst_dir", 16'(err_dir), 16'h0);
    check("rst_phase", phase_cnt, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int rdir, rph, rleft, rd;
    logic [1:0] v [4];
    logic [1:0] code;
    model_reset();
    pulse_seen = 0; step_no = 0; pulse_at = 0;
    repeat (2) @(posedge clk);
    #1;
    check("init_pulse", 16'(err_pulse), 16'h0);
    check("init_flags", 16'(err_flags), 16'h0);
    check("init_phase", phase_cnt, 16'h0);
    rst_n = 1'b1;

    // legal round robin
    step(0, 0, 0, 0, 1'b0);
    for (int d = 0; d < 4; d++) begin
      step_dir(d, 2'b10, 10);
      step_dir(d, 2'b01, 4);
      step_dir(d, 2'b00, 2);
    end
    check("legal_pulses", 16'(pulse_seen), 16'h0);
    check("legal_flags", 16'(err_flags), 16'h0);
    check("legal_phase", phase_cnt, 16'd4);
    settle();

    // conflict: W turns green while S green
    step_dir(0, 2'b10, 4);
    step(2'b10, 2'b10, 0, 0, 1'b0);
    step(2'b10, 2'b10, 0, 0, 1'b0);
    check("conf_pulse", 16'(err_pulse), 16'h1);
    check("conf_flags", 16'(err_flags), 16'h02);
    check("conf_dir", 16'(err_dir), 16'h1);
    settle();

    // green straight to red
    step_dir(2, 2'b10, 8);
    step_dir(2, 2'b00, 2);
    check("g2r_flags", 16'(err_flags), 16'h04);
    check("g2r_dir", 16'(err_dir), 16'h2);
    check("g2r_phase", phase_cnt, 16'h1);
    settle();

    // yellow dwell too short then too long
    step_dir(3, 2'b10, 5); step_dir(3, 2'b01, 2); step_dir(3, 2'b00, 3);
    step_dir(3, 2'b10, 5); step_dir(3, 2'b01, 7); step_dir(3, 2'b00, 3);
    check("ydw_pulses", 16'(pulse_seen), 16'd2);
    check("ydw_flags", 16'(err_flags), 16'h08);
    settle();

    // green held too long
    step_dir(1, 2'b10, 30); step_dir(1, 2'b01, 4); step_dir(1, 2'b00, 3);
    check("gdw_pulses", 16'(pulse_seen), 16'd1);
    check("gdw_when", 16'(pulse_at), 16'd22);
    check("gdw_flags", 16'(err_flags), 16'h10);
    settle();

    // invalid code, then asynchronous reset
    step(2'b11, 0, 0, 0, 1'b0);
    step(0, 0, 0, 0, 1'b0);
    check("inv_flags", 16'(err_flags), 16'h01);
    check("inv_dir", 16'(err_dir), 16'h0);
    async_reset();
    pulse_seen = 0;
    step_dir(1, 2'b01, 4);
    step_dir(1, 2'b00, 3);
    check("post_rst_pulses", 16'(pulse_seen), 16'h0);
    check("post_rst_flags", 16'(err_flags), 16'h0);

    // randomized controller-like traffic with glitches, clears and resets
    rdir = 0; rph = 2; rleft = 1;
    for (int i = 0; i < 900; i++) begin
      if (rleft == 0) begin
        rph = (rph + 1) % 3;
        if (rph == 0) begin rdir = (rdir + 1) % 4; rleft = $urandom_range(1, 26); end
        else if (rph == 1) rleft = $urandom_range(1, 8);
        else rleft = $urandom_range(1, 3);
      end
      rleft--;
      code = (rph == 0) ? 2'b10 : (rph == 1) ? 2'b01 : 2'b00;
      for (int k = 0; k < 4; k++) v[k] = 2'b00;
      v[rdir] = code;
      if ($urandom_range(0, 11) == 0) begin
        rd = $urandom_range(0, 3);
        v[rd] = 2'($urandom_range(0, 3));
      end
      step(v[0], v[1], v[2], v[3], ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
